// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO pair.
// One result bit per cycle on a 32-bit add/subtract path; stalls the pipeline while busy.
module muldiv_sequencer #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    // state | meaning
    // IDLE  | waiting for start; MTHI/MTLO accepted
    // PREP  | signed operands to magnitudes, record signs, clear work/counter
    // CALC  | one multiply/divide step per cycle, ITER cycles
    // FIX   | apply signs / divide-by-zero result, write HI/LO
    // DONE  | result visible, done pulse; start accepted here too
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   a_raw_q, a_raw_d;
    logic [63:0]   work_q, work_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          res_neg_q, res_neg_d;
    logic          rem_neg_q, rem_neg_d;
    logic          dbz_q, dbz_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          is_signed, is_div;
    logic [32:0]   mul_sum;
    logic [32:0]   rem_sh;
    logic          rem_ge;
    logic [31:0]   rem_sub;
    logic [31:0]   quo_fix, rem_fix;
    logic [63:0]   prod_fix;

    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];

    always_comb begin
        mul_sum  = {1'b0, work_q[63:32]} + {1'b0, b_q};
        rem_sh   = {work_q[63:32], a_q[31]};
        rem_ge   = (rem_sh >= {1'b0, b_q});
        rem_sub  = rem_sh[31:0] - b_q;
        quo_fix  = res_neg_q ? -work_q[31:0] : work_q[31:0];
        rem_fix  = rem_neg_q ? -work_q[63:32] : work_q[63:32];
        prod_fix = res_neg_q ? -work_q : work_q;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        a_raw_d   = a_raw_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        // MTHI/MTLO only land while idle; a result written later overwrites them.
        if (!busy) begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = A;
                    a_raw_d = A;
                    b_d     = B;
                    state_d = S_PREP;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_PREP: begin
                if (is_signed) begin
                    a_d       = a_q[31] ? -a_q : a_q;
                    b_d       = b_q[31] ? -b_q : b_q;
                    res_neg_d = a_q[31] ^ b_q[31];
                    rem_neg_d = a_q[31];
                end else begin
                    res_neg_d = 1'b0;
                    rem_neg_d = 1'b0;
                end
                work_d  = '0;
                cnt_d   = '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                if (is_div) begin
                    // Dividend bits enter MSB-first from a_q; quotient collects in work low half.
                    work_d = rem_ge ? {rem_sub, work_q[30:0], 1'b1}
                                    : {rem_sh[31:0], work_q[30:0], 1'b0};
                    a_d    = {a_q[30:0], 1'b0};
                end else begin
                    work_d = a_q[0] ? {mul_sum, work_q[31:1]} : {1'b0, work_q[63:1]};
                    a_d    = {1'b0, a_q[31:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                dbz_d = 1'b0;
                if (!is_div) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (b_q == 32'd0) begin
                    hi_d  = a_raw_q;
                    lo_d  = 32'hFFFF_FFFF;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_raw_q   <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_raw_q   <= a_raw_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
    assign stall       = busy;
    assign done        = (state_q == S_DONE);
    assign div_by_zero = done & dbz_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed corner cases plus random operations,
// expected results queued at issue and checked by an independent monitor on done.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] HI, LO;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t exp_q[$];

    muldiv_sequencer #(.ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference results from plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          sa, sb;
        longint      sp;
        logic [63:0] p;
        sa = a;
        sb = b;
        e.hi = '0; e.lo = '0; e.dbz = 1'b0; e.due = 0;
        case (o)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                p = 64'(sp);
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = 32'h8000_0000; e.hi = 32'd0;
                    end else begin
                        e.lo = sa / sb; e.hi = sa % sb;
                    end
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset !== 1'b1) check("stall_eq_busy", {63'b0, stall}, {63'b0, busy});
        if (div_by_zero === 1'b1) check("dbz_implies_done", {63'b0, done}, 64'd1);
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_latency", 64'(cyc), 64'(e.due));
                check("HI", {32'b0, HI}, {32'b0, e.hi});
                check("LO", {32'b0, LO}, {32'b0, e.lo});
                check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
        int   guard;
        exp_t e;
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("issue_timeout", 64'd1, 64'd0);
        start = 1'b1; op = o; A = a; B = b;
        n = cyc;
        e = model(o, a, b);
        e.due = cyc + 35;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int n, bc;
        issue(o, a, b, n);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(bc), 64'd34);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 100) begin
            g++;
            @(negedge clk);
        end
        if (g >= 100) check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int          n, n2, g;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_stall", {63'b0, stall}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        check("rst_HI", {32'b0, HI}, 64'd0);
        check("rst_LO", {32'b0, LO}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b11, 32'h1234_5678, 32'd0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0);

        // Reset in cycle 10 of a running MULTU aborts it with no HI/LO write.
        issue(2'b01, 32'd5, 32'd6, n);
        while (cyc < n + 10) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_HI", {32'b0, HI}, 64'd0);
        check("abort_LO", {32'b0, LO}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        run_op(2'b01, 32'd5, 32'd6);

        // Start while busy is ignored; start in the DONE cycle is accepted.
        issue(2'b11, 32'd100, 32'd7, n);
        while (cyc < n + 20) @(negedge clk);
        start = 1'b1; op = 2'b11; A = 32'd9; B = 32'd4;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("b2b_in_done", {63'b0, done}, 64'd1);
        issue(2'b11, 32'd9, 32'd4, n2);
        wait_idle();
        @(negedge clk);

        // MTHI/MTLO while idle, write dropped while busy, write+start same cycle.
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", {32'b0, HI}, {32'b0, 32'hDEAD_BEEF});
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        issue(2'b11, 32'd1000, 32'd3, n);
        lo_we = 1'b0;
        check("mtlo_with_start", {32'b0, LO}, {32'b0, 32'hCAFE_F00D});
        hi_we = 1'b1; wdata = 32'h1111_1111;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_busy_dropped", {32'b0, HI}, {32'b0, 32'hDEAD_BEEF});
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = 32'($urandom_range(0, 255));
            run_op(ro, ra, rb);
        end

        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            g++;
            @(negedge clk);
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
